disp_ctrl_lanes: RTL

Multi-lane 8b/10b running-disparity controller. It classifies each lane's 5B/6B and 3B/4B sub-blocks and chains the running disparity (RD) across LANES bytes per beat, using a single clock edge. It emits per-lane complement flags to the 5B/6B and 3B/4B encoding stages, and holds the link RD between beats. It sits between the per-byte L-function/classification logic and the sub-block encoders, with a valid/ready handshake and one registered output stage.

---
 rtl/disp_pkg.sv | 29 ++
 rtl/disp_lane.sv | 50 +++++
 rtl/disp_ctrl_lanes.sv | 103 ++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Field positions and constants shared by the disparity controller and its lane slice.
package disp_pkg;

  localparam int unsigned L_W  = 6;
  localparam int unsigned D_W  = 5;
  localparam int unsigned DE_W = 2;

  // l_in lane field: {L40,L31,L22,L13,L04,K}
  localparam int unsigned L_K   = 0;
  localparam int unsigned L_L04 = 1;
  localparam int unsigned L_L13 = 2;
  localparam int unsigned L_L22 = 3;
  localparam int unsigned L_L31 = 4;
  localparam int unsigned L_L40 = 5;

  // d_in lane field: {S,K4,H4,G4,F4}
  localparam int unsigned D_F4 = 0;
  localparam int unsigned D_G4 = 1;
  localparam int unsigned D_H4 = 2;
  localparam int unsigned D_K4 = 3;
  localparam int unsigned D_S  = 4;

  // de_in lane field: {D,E}
  localparam int unsigned DE_E = 0;
  localparam int unsigned DE_D = 1;

  localparam logic RD_NEG = 1'b0;

endpackage

// File: rtl/disp_lane.sv
// One lane of the disparity chain: sub-block classification plus 6b/4b complement
// decisions, taking the entry RD and producing the RD after the 4b sub-block.
module disp_lane
  import disp_pkg::*;
(
  input  logic            rd_entry,
  input  logic [L_W-1:0]  l,
  input  logic [D_W-1:0]  d,
  input  logic [DE_W-1:0] de,
  output logic            c6,
  output logic            c4,
  output logic            rd_exit
);

  logic k, l31, l22, l13, dd, e, f4, g4, h4, k4;
  logic pd1s6, nd0s6, nd1s6, pd0s6;
  logic nd1s4, nd0s4, pd1s4, pd0s4;
  logic rd6;
  logic unused_ok;

  assign k   = l[L_K];
  assign l31 = l[L_L31];
  assign l22 = l[L_L22];
  assign l13 = l[L_L13];
  assign dd  = de[DE_D];
  assign e   = de[DE_E];
  assign f4  = d[D_F4];
  assign g4  = d[D_G4];
  assign h4  = d[D_H4];
  assign k4  = d[D_K4];

  // L40/L04 do not enter the equations; S only steers alternate D.x.7 downstream.
  assign unused_ok = ^{l[L_L40], l[L_L04], d[D_S]};

  assign pd1s6 = (l13 & dd & e) | (~l22 & ~l31 & ~e);
  assign nd0s6 = pd1s6;
  assign nd1s6 = k | (l31 & ~dd & ~e) | (e & ~l22 & ~l13);
  assign pd0s6 = k | (e & ~l22 & ~l13);

  assign nd1s4 = f4 & g4;
  assign nd0s4 = ~f4 & ~g4;
  assign pd1s4 = nd0s4 | (k4 & (f4 ^ g4));
  assign pd0s4 = f4 & g4 & h4;

  assign c6      = (pd1s6 & ~rd_entry) | (nd1s6 & rd_entry);
  assign rd6     = (pd0s6 & ~c6) | (nd0s6 & c6) | (~pd0s6 & ~nd0s6 & rd_entry);
  assign c4      = (pd1s4 & ~rd6) | (nd1s4 & rd6);
  assign rd_exit = (pd0s4 & ~c4) | (nd0s4 & c4) | (~pd0s4 & ~nd0s4 & rd6);

endmodule

// File: rtl/disp_ctrl_lanes.sv
// Multi-lane 8b/10b running-disparity controller with a valid/ready registered output.
// Optional macro DISP_FORCE_EN adds rd_force/rd_force_val to override the link RD.
module disp_ctrl_lanes
  import disp_pkg::*;
#(
  parameter int unsigned LANES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [L_W*LANES-1:0]  l_in,
  input  logic [D_W*LANES-1:0]  d_in,
  input  logic [DE_W*LANES-1:0] de_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES-1:0]      compls6,
  output logic [LANES-1:0]      compls4,
  output logic                  rd_out
`ifdef DISP_FORCE_EN
  ,
  input  logic                  rd_force,
  input  logic                  rd_force_val
`endif
);

  logic             rd_q, rd_d;
  logic             out_valid_q, out_valid_d;
  logic [LANES-1:0] compls6_q, compls6_d;
  logic [LANES-1:0] compls4_q, compls4_d;
  logic             rd_out_q, rd_out_d;
  logic             accept;
  logic [LANES:0]   rd_chain;
  logic [LANES-1:0] c6_lane, c4_lane;

  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;

`ifdef DISP_FORCE_EN
  assign rd_chain[0] = rd_force ? rd_force_val : rd_q;
`else
  assign rd_chain[0] = rd_q;
`endif

  // RD ripples lane 0 -> LANES-1 within the beat
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    disp_lane u_lane (
      .rd_entry (rd_chain[i]),
      .l        (l_in[L_W*i +: L_W]),
      .d        (d_in[D_W*i +: D_W]),
      .de       (de_in[DE_W*i +: DE_W]),
      .c6       (c6_lane[i]),
      .c4       (c4_lane[i]),
      .rd_exit  (rd_chain[i+1])
    );
  end

  always_comb begin
    rd_d        = rd_q;
    out_valid_d = out_valid_q;
    compls6_d   = compls6_q;
    compls4_d   = compls4_q;
    rd_out_d    = rd_out_q;
    if (accept) begin
      rd_d        = rd_chain[LANES];
      out_valid_d = 1'b1;
      compls6_d   = c6_lane;
      compls4_d   = c4_lane;
      rd_out_d    = rd_chain[LANES];
    end else begin
      if (out_ready) begin
        out_valid_d = 1'b0;
      end
`ifdef DISP_FORCE_EN
      if (rd_force) begin
        rd_d = rd_force_val;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q        <= RD_NEG;
      out_valid_q <= 1'b0;
      compls6_q   <= '0;
      compls4_q   <= '0;
      rd_out_q    <= RD_NEG;
    end else begin
      rd_q        <= rd_d;
      out_valid_q <= out_valid_d;
      compls6_q   <= compls6_d;
      compls4_q   <= compls4_d;
      rd_out_q    <= rd_out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign compls6   = compls6_q;
  assign compls4   = compls4_q;
  assign rd_out    = rd_out_q;

endmodule
